// File: rtl/rvdff_pipe_if.sv
// rvdff_pipe_if: valid/ready handshake bundle for the rvdff_pipe register pipeline
interface rvdff_pipe_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
);
  logic                         in_valid;
  logic                         in_ready;
  logic [WIDTH-1:0]             din;
  logic                         out_valid;
  logic                         out_ready;
  logic [WIDTH-1:0]             dout;
  logic [$clog2(DEPTH+1)-1:0]   occupancy;
  modport master (
    output in_valid, din, out_ready,
    input  in_ready, out_valid, dout, occupancy
  );
  modport slave (
    input  in_valid, din, out_ready,
    output in_ready, out_valid, dout, occupancy
  );
endinterface

// File: rtl/rvdff_pipe.sv
// rvdff_pipe: DEPTH-stage valid/ready register pipeline with bubble collapse and flush
module rvdff_pipe #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  rvdff_pipe_if.slave  bus
);
  localparam int OW = $clog2(DEPTH+1);
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] src_vld;
  logic [WIDTH-1:0] dat     [DEPTH];
  logic [WIDTH-1:0] src_dat [DEPTH];
  logic [OW-1:0]    occ;
  // a stage can take a new value when it is empty or its content moves on
  always_comb begin
    load = '0;
    load[DEPTH-1] = !vld[DEPTH-1] || bus.out_ready;
    for (int k = DEPTH-2; k >= 0; k--) load[k] = !vld[k] || load[k+1];
  end
  assign bus.in_ready = load[0] && !flush;
  // each stage is fed by its predecessor; stage 0 is fed by an accepted din
  always_comb begin
    src_vld[0] = bus.in_valid && bus.in_ready;
    src_dat[0] = bus.din;
    for (int k = 1; k < DEPTH; k++) begin
      src_vld[k] = vld[k-1];
      src_dat[k] = dat[k-1];
    end
  end
  // valid bits clear on flush; data registers only capture real items
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld <= '0;
      for (int k = 0; k < DEPTH; k++) dat[k] <= RESET_VAL;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (flush) vld[k] <= 1'b0;
        else if (load[k]) vld[k] <= src_vld[k];
        if (!flush && load[k] && src_vld[k]) dat[k] <= src_dat[k];
      end
    end
  // occupancy is a population count of the valid bits
  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) occ = occ + OW'(vld[k]);
  end
  assign bus.out_valid = vld[DEPTH-1];
  assign bus.dout      = dat[DEPTH-1];
  assign bus.occupancy = occ;
endmodule

// File: tb/tb_rvdff_pipe.sv
// tb_rvdff_pipe: scoreboard bench for rvdff_pipe with a timing-rule reference model
module tb_rvdff_pipe;
  localparam int D = 3;
  localparam logic [7:0] RV = 8'hA5;
  typedef struct { logic [7:0] data; int acc; } item_t;
  logic clk = 0;
  logic rst = 0;
  logic flush = 0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int last_out = -100;
  int n;
  logic exp_ov;
  item_t q[$];
  rvdff_pipe_if #(.WIDTH(8), .DEPTH(D)) bus();
  rvdff_pipe #(.WIDTH(8), .DEPTH(D), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", name, got, exp, cyc);
    end
  endtask
  task automatic step(input logic iv, input logic [7:0] d, input logic orr, input logic fl, output logic acc);
    @(posedge clk);
    #1;
    bus.in_valid = iv;
    bus.din = d;
    bus.out_ready = orr;
    flush = fl;
    #3;
    acc = bus.in_valid && bus.in_ready;
    if (acc) q.push_back('{d, cyc});
  endtask
  // Model: items leave in acceptance order; an item reaches the output DEPTH
  // cycles after acceptance, but never before the cycle after its predecessor left.
  always @(negedge clk) if (!rst) begin
    n = 0;
    foreach (q[i]) if (q[i].acc < cyc) n++;
    exp_ov = n > 0 && cyc >= q[0].acc + D && cyc >= last_out + 1;
    chk("occupancy", 32'(bus.occupancy), 32'(n));
    chk("in_ready", 32'(bus.in_ready), 32'((n < D || bus.out_ready) && !flush));
    chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    if (exp_ov) chk("dout", 32'(bus.dout), 32'(q[0].data));
    if (flush) q.delete();
    else if (exp_ov && bus.out_ready) begin
      void'(q.pop_front());
      last_out = cyc;
    end
  end
  initial begin
    logic acc;
    int idx;
    bus.in_valid = 0;
    bus.din = '0;
    bus.out_ready = 0;
    #1 rst = 1;
    #1;
    chk("reset_dout", 32'(bus.dout), 32'(RV));
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_occupancy", 32'(bus.occupancy), 0);
    chk("reset_in_ready", 32'(bus.in_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    step(1, 8'h11, 1, 0, acc);
    step(1, 8'h22, 1, 0, acc);
    step(1, 8'h33, 1, 0, acc);
    repeat (5) step(0, 8'h00, 1, 0, acc);
    idx = 0;
    for (int c = 0; c < 20 && !(idx == 5 && q.size() == 0); c++) begin
      step(idx < 5, 8'(idx + 1), c >= 6, 0, acc);
      if (acc) idx++;
    end
    chk("fill_all_accepted", 32'(idx), 5);
    repeat (4) step(0, 8'h00, 1, 0, acc);
    step(1, 8'h40, 0, 0, acc);
    step(1, 8'h41, 0, 0, acc);
    step(1, 8'h42, 1, 1, acc);
    chk("flush_accept", 32'(acc), 0);
    step(0, 8'h00, 1, 0, acc);
    repeat (4) step(1, 8'($urandom), 0, 0, acc);
    step(0, 8'h00, 0, 0, acc);
    @(negedge clk);
    #1 rst = 1;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_dout", 32'(bus.dout), 32'(RV));
    chk("midrst_occupancy", 32'(bus.occupancy), 0);
    chk("midrst_in_ready", 32'(bus.in_ready), 1);
    q.delete();
    last_out = -100;
    #1 rst = 0;
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0, acc);
    repeat (12) step(0, 8'h00, 1, 0, acc);
    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
